data_ram_ctrl: RTL and testbench

//  Memory-access sequencer sitting directly upstream of the data RAM. It takes one

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/data_ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_ram_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-RAM access path: request op codes and the
// sequencer state encoding, reused by the control unit and verification.
package data_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'b00,
    OP_STORE    = 2'b01,
    OP_LOAD_IND = 2'b10,
    OP_RSVD     = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for RAM reads: synchronous clear, count enable, saturation at
// TIMEOUT and a terminal flag raised while the count sits at TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != CNT_W'(TIMEOUT))) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign term = (cnt_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-RAM access sequencer: accepts one load/store/indirect-load request at a
// time, drives registered RAM strobes and returns a one-cycle response pulse.
module data_ram_ctrl
  import data_mem_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LENGTH  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqOp,
  input  logic [LENGTH-1:0] reqAddr,
  input  logic [WIDTH-1:0]  reqData,
  output logic              rspValid,
  output logic              rspError,
  output logic [WIDTH-1:0]  rspData,
  output logic [LENGTH-1:0] ramAddr,
  output logic [WIDTH-1:0]  ramWriteData,
  output logic              ramWriteEnable,
  output logic              ramReadEnable,
  output logic              ramIndirect,
  input  logic              ramDataReady,
  input  logic [WIDTH-1:0]  ramReadData
);

  state_t            state_reg, state_next;
  logic              ready_reg, ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_error_reg, rsp_error_next;
  logic [WIDTH-1:0]  rsp_data_reg, rsp_data_next;
  logic [LENGTH-1:0] addr_reg, addr_next;
  logic [WIDTH-1:0]  wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              re_reg, re_next;
  logic              ind_reg, ind_next;

  logic              timer_clear;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_term;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk   (clk),
    .clr   (clr),
    .clear (timer_clear),
    .enable(state_reg == READ),
    .cnt   (wait_cnt),
    .term  (wait_term)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_error_reg <= 1'b0;
      rsp_data_reg  <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      ind_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_error_reg <= rsp_error_next;
      rsp_data_reg  <= rsp_data_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      re_reg        <= re_next;
      ind_reg       <= ind_next;
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_next     = state_reg;
    ready_next     = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_error_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    we_next        = 1'b0;
    re_next        = 1'b0;
    ind_next       = 1'b0;
    timer_clear    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (reqValid && ready_reg) begin
          ready_next = 1'b0;
          addr_next  = reqAddr;
          wdata_next = reqData;
          case (op_t'(reqOp))
            OP_STORE: begin
              state_next = WRITE;
              we_next    = 1'b1;
            end
            OP_LOAD, OP_LOAD_IND: begin
              state_next  = READ;
              re_next     = 1'b1;
              ind_next    = (op_t'(reqOp) == OP_LOAD_IND);
              timer_clear = 1'b1;
            end
            default: begin
              state_next     = DONE;
              rsp_valid_next = 1'b1;
              rsp_error_next = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        state_next     = DONE;
        rsp_valid_next = 1'b1;
      end
      READ: begin
        re_next  = 1'b1;
        ind_next = ind_reg;
        // A ready flag in the first READ cycle belongs to an earlier access.
        if (ramDataReady && (wait_cnt != '0)) begin
          state_next     = DONE;
          rsp_valid_next = 1'b1;
          rsp_data_next  = ramReadData;
          re_next        = 1'b0;
          ind_next       = 1'b0;
        end else if (wait_term) begin
          state_next     = DONE;
          rsp_valid_next = 1'b1;
          rsp_error_next = 1'b1;
          rsp_data_next  = '0;
          re_next        = 1'b0;
          ind_next       = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase
  end

  assign reqReady       = ready_reg;
  assign rspValid       = rsp_valid_reg;
  assign rspError       = rsp_error_reg;
  assign rspData        = rsp_data_reg;
  assign ramAddr        = addr_reg;
  assign ramWriteData   = wdata_reg;
  assign ramWriteEnable = we_reg;
  assign ramReadEnable  = re_reg;
  assign ramIndirect    = ind_reg;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: transaction-timeline model checked every cycle,
// a small RAM model, and directed requests with hand-computed expectations.
module tb_data_ram_ctrl;
  import data_mem_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       reqValid = 1'b0;
  logic       reqReady;
  logic [1:0] reqOp = 2'b00;
  logic [7:0] reqAddr = 8'h00;
  logic [7:0] reqData = 8'h00;
  logic       rspValid, rspError;
  logic [7:0] rspData, ramAddr, ramWriteData;
  logic       ramWriteEnable, ramReadEnable, ramIndirect;
  logic       ramDataReady = 1'b0;
  logic [7:0] ramReadData = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int ram_mode = 0;  // 0: one-cycle RAM, 1: never ready, 2: ready stuck high

  logic [7:0] mem [256];

  data_ram_ctrl #(.WIDTH(8), .LENGTH(8), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspError(rspError), .rspData(rspData),
    .ramAddr(ramAddr), .ramWriteData(ramWriteData),
    .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
    .ramIndirect(ramIndirect), .ramDataReady(ramDataReady),
    .ramReadData(ramReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWriteEnable) mem[ramAddr] <= ramWriteData;
    ramReadData  <= ramIndirect ? mem[mem[ramAddr]] : mem[ramAddr];
    ramDataReady <= (ram_mode == 0) ? ramReadEnable : (ram_mode == 2);
  end

  // Timeline model: k counts edges since acceptance, fin is the edge whose
  // response is visible; the request retires on the edge after fin.
  logic       m_busy = 1'b0;
  int         m_k = 0;
  int         m_fin = -1;
  logic [1:0] m_op = 2'b00;
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00;
  logic       m_err = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy = 1'b0; m_k = 0; m_fin = -1; m_err = 1'b0;
      m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00;
    end else if (!m_busy) begin
      if (reqValid) begin
        m_busy = 1'b1; m_k = 0; m_op = reqOp;
        m_addr = reqAddr; m_wdata = reqData;
        m_err  = (reqOp == OP_RSVD);
        m_fin  = (reqOp == OP_STORE) ? 1 : (reqOp == OP_RSVD) ? 0 : -1;
      end
    end else begin
      m_k = m_k + 1;
      if (m_fin < 0 && m_k >= 2 && ramDataReady) begin
        m_fin = m_k; m_rdata = ramReadData; m_err = 1'b0;
      end else if (m_fin < 0 && m_k == TIMEOUT + 1) begin
        m_fin = m_k; m_rdata = 8'h00; m_err = 1'b1;
      end else if (m_fin >= 0 && m_k == m_fin + 1) begin
        m_busy = 1'b0;
      end
    end
  end

  logic exp_we, exp_re, exp_ind, exp_rsp;
  assign exp_we  = m_busy && (m_op == OP_STORE) && (m_k == 0);
  assign exp_re  = m_busy && (m_op == OP_LOAD || m_op == OP_LOAD_IND) && (m_fin < 0);
  assign exp_ind = exp_re && (m_op == OP_LOAD_IND);
  assign exp_rsp = m_busy && (m_fin >= 0) && (m_k == m_fin);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("cyc_reqReady", 32'(reqReady), 32'(!m_busy));
    chk("cyc_we", 32'(ramWriteEnable), 32'(exp_we));
    chk("cyc_re", 32'(ramReadEnable), 32'(exp_re));
    chk("cyc_ind", 32'(ramIndirect), 32'(exp_ind));
    chk("cyc_rspValid", 32'(rspValid), 32'(exp_rsp));
    chk("cyc_rspError", 32'(rspError), 32'(exp_rsp && m_err));
    chk("cyc_rspData", 32'(rspData), 32'(m_rdata));
    chk("cyc_ramAddr", 32'(ramAddr), 32'(m_addr));
    chk("cyc_ramWData", 32'(ramWriteData), 32'(m_wdata));
  end

  int         r_lat, r_we, r_re, r_ind;
  logic       r_err;
  logic [7:0] r_rd, r_we_addr, r_we_data;

  // r_lat = edges after the accepting edge until rspValid is seen.
  task automatic run_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    reqValid = 1'b1; reqOp = op; reqAddr = addr; reqData = data;
    @(posedge clk); #1;
    reqValid = 1'b0;
    n = 0; r_lat = -1; r_we = 0; r_re = 0; r_ind = 0;
    r_err = 1'b0; r_rd = 8'h00; r_we_addr = 8'h00; r_we_data = 8'h00;
    while (r_lat < 0 && n < 40) begin
      if (ramWriteEnable) begin r_we++; r_we_addr = ramAddr; r_we_data = ramWriteData; end
      if (ramReadEnable) r_re++;
      if (ramIndirect) r_ind++;
      if (rspValid) begin
        r_lat = n; r_err = rspError; r_rd = rspData;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    chk("rsp_seen", 32'(r_lat >= 0), 32'd1);
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rspValid), 32'd0);
    chk("ready_back", 32'(reqReady), 32'd1);
    $display("txn op=%0d addr=%02h data=%02h lat=%0d err=%0d rsp=%02h", op, addr, data, r_lat, r_err, r_rd);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(reqReady), 32'd1);
    chk("rst_rsp", 32'(rspValid), 32'd0);
    chk("rst_data", 32'(rspData), 32'd0);
    chk("rst_strobes", 32'({ramWriteEnable, ramReadEnable, ramIndirect}), 32'd0);
    @(negedge clk) clr = 1'b1;

    run_req(OP_STORE, 8'h12, 8'hA5);
    chk("st_lat", r_lat, 1);
    chk("st_we_cycles", r_we, 1);
    chk("st_we_addr", 32'(r_we_addr), 32'h12);
    chk("st_we_data", 32'(r_we_data), 32'hA5);
    chk("st_err", 32'(r_err), 32'd0);
    chk("st_rd_kept", 32'(r_rd), 32'h00);

    run_req(OP_LOAD, 8'h12, 8'h00);
    chk("ld_lat", r_lat, 2);
    chk("ld_data", 32'(r_rd), 32'hA5);
    chk("ld_ind", r_ind, 0);
    chk("ld_err", 32'(r_err), 32'd0);

    run_req(OP_STORE, 8'h20, 8'h40);
    run_req(OP_STORE, 8'h40, 8'h3C);
    chk("st2_rd_kept", 32'(r_rd), 32'hA5);
    run_req(OP_LOAD_IND, 8'h20, 8'h00);
    chk("ind_data", 32'(r_rd), 32'h3C);
    chk("ind_cycles", r_ind, 2);
    chk("ind_re_cycles", r_re, 2);
    chk("ind_err", 32'(r_err), 32'd0);

    ram_mode = 1;
    run_req(OP_LOAD, 8'h12, 8'h00);
    chk("to_lat", r_lat, TIMEOUT + 1);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_data", 32'(r_rd), 32'h00);
    chk("to_re_cycles", r_re, TIMEOUT + 1);
    ram_mode = 0;
    run_req(OP_LOAD, 8'h12, 8'h00);
    chk("after_to_data", 32'(r_rd), 32'hA5);
    chk("after_to_lat", r_lat, 2);

    ram_mode = 2;
    run_req(OP_LOAD, 8'h40, 8'h00);
    chk("stale_lat", r_lat, 2);
    chk("stale_data", 32'(r_rd), 32'h3C);
    ram_mode = 0;

    @(negedge clk);
    reqValid = 1'b1; reqOp = OP_RSVD; reqAddr = 8'h55; reqData = 8'h66;
    @(posedge clk); #1;
    chk("rsvd_rsp", 32'(rspValid), 32'd1);
    chk("rsvd_err", 32'(rspError), 32'd1);
    chk("rsvd_strobes", 32'({ramWriteEnable, ramReadEnable}), 32'd0);
    chk("rsvd_busy", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    chk("rsvd_no_accept_rsp", 32'(rspValid), 32'd0);
    chk("rsvd_idle_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    chk("rsvd_second_rsp", 32'(rspValid), 32'd1);
    reqValid = 1'b0;
    @(posedge clk); #1;
    chk("rsvd_data_kept", 32'(rspData), 32'h3C);
    $display("txn op=3 addr=55 held twice");

    ram_mode = 1;
    @(negedge clk);
    reqValid = 1'b1; reqOp = OP_LOAD_IND; reqAddr = 8'h20;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_ind", 32'(ramIndirect), 32'd1);
    #1 clr = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({ramWriteEnable, ramReadEnable, ramIndirect}), 32'd0);
    chk("mid_rst_ready", 32'(reqReady), 32'd1);
    chk("mid_rst_rsp", 32'(rspValid), 32'd0);
    chk("mid_rst_data", 32'(rspData), 32'd0);
    @(negedge clk) clr = 1'b1;
    ram_mode = 0;
    begin
      int rsp_cnt = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (rspValid) rsp_cnt++;
      end
      chk("post_rst_no_rsp", rsp_cnt, 0);
    end
    $display("txn reset during indirect load");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
